sar_search: RTL and testbench

Successive-approximation search controller. It discovers an unknown W-bit target value by driving trial values into a magnitude comparator and steering on the comparator's greater/less/equal flags. It is the initiator side of the comparator interface: it produces the `a` operand and consumes `agb`/`asb`/`aeb`, while the target sits on the comparator's `b` operand. The comparator itself stays outside the block.

---
 rtl/sar_pkg.sv | 5 +
 rtl/sar_search.sv | 63 ++++++
 tb/tb_sar_search.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and default width for the successive-approximation search controller
package sar_pkg;
    typedef enum logic {SAR_IDLE, SAR_SEARCH} sar_state_t;
    localparam int SAR_W_DEFAULT = 4;
endpackage

// File: rtl/sar_search.sv
// sar_search: successive-approximation search steering an external magnitude comparator
module sar_search
    import sar_pkg::*;
#(
    parameter int W = SAR_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         agb,
    input  logic         asb,
    input  logic         aeb,
    output logic [W-1:0] probe,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         found,
    output logic         err
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    sar_state_t   state;
    logic [IW-1:0] idx;
    logic [W-1:0] bit_i, bit_n;
    logic         one_hot;
    assign bit_i   = W'(1) << idx;
    assign bit_n   = bit_i >> 1;
    assign one_hot = (agb ^ asb ^ aeb) & ~(agb & asb & aeb);
    // A search ends on bad flags, an exact hit, or after the last bit is resolved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= SAR_IDLE;
            probe  <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == SAR_IDLE) begin
                if (start) begin
                    state <= SAR_SEARCH;
                    busy  <= 1'b1;
                    probe <= W'(1) << (W - 1);
                    idx   <= IW'(W - 1);
                    found <= 1'b0;
                    err   <= 1'b0;
                end
            end else if (!one_hot || aeb || idx == '0) begin
                state  <= SAR_IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= (one_hot && agb) ? (probe & ~W'(1)) : probe;
                found  <= one_hot && !asb;
                err    <= !one_hot || asb;
            end else begin
                probe <= agb ? ((probe & ~bit_i) | bit_n) : (probe | bit_n);
                idx   <= idx - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: closed-loop bench with a behavioural 4-bit comparator and a result scoreboard
module tb_sar_search;
    typedef struct {
        logic [3:0] r;
        logic       f;
        logic       e;
        int         k;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       agb, asb, aeb;
    logic [3:0] probe, result;
    logic       busy, done, found, err;
    logic [3:0] target = 4'd0;
    logic       ovr = 1'b0;
    logic [2:0] ovr_fl = 3'b000;
    logic       hold = 1'b0;
    int         checks = 0;
    int         failures = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    // Comparator model with an override path for injecting faulty flags.
    assign agb = ovr ? ovr_fl[2] : (probe > target);
    assign asb = ovr ? ovr_fl[1] : (probe < target);
    assign aeb = ovr ? ovr_fl[0] : (probe == target);

    sar_search #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .agb(agb), .asb(asb), .aeb(aeb),
        .probe(probe), .busy(busy), .done(done),
        .result(result), .found(found), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compares needed = 4 - position of lowest set bit (4 for target 0).
    function automatic exp_t good(input logic [3:0] t);
        exp_t e;
        bit   hit = 1'b0;
        e.r = t;
        e.f = 1'b1;
        e.e = 1'b0;
        e.k = 4;
        for (int i = 0; i < 4; i++)
            if (t[i] && !hit) begin
                e.k = 4 - i;
                hit = 1'b1;
            end
        return e;
    endfunction

    task automatic push(input logic [3:0] r, input logic f, input logic e, input int k);
        exp_t x;
        x.r = r;
        x.f = f;
        x.e = e;
        x.k = k;
        sb.push_back(x);
    endtask

    task automatic launch(input logic [3:0] t);
        target = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        check("start_busy", busy, 1);
        check("start_probe", probe, 4'b1000);
    endtask

    task automatic wait_done(input int fn, input logic [2:0] ff, input bit poke);
        int   cnt = 0;
        exp_t e;
        while (!done && cnt < 12) begin
            ovr = (fn == cnt + 1);
            ovr_fl = ff;
            start = hold | (poke && cnt == 1);
            @(posedge clk);
            #1;
            cnt++;
            ovr = 1'b0;
        end
        start = hold;
        check("done_seen", done, 1);
        if (sb.size() == 0) begin
            check("sb_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check("result", result, e.r);
            check("found", found, e.f);
            check("err", err, e.e);
            check("latency", cnt, e.k);
            check("busy_at_done", busy, 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_probe"}, probe, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        push(4'd5, 1, 0, 4);
        launch(4'd5);
        wait_done(0, 3'b000, 0);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("result_held", result, 4'd5);

        sb.push_back(good(4'd8));  launch(4'd8);  wait_done(0, 3'b000, 0);
        sb.push_back(good(4'd0));  launch(4'd0);  wait_done(0, 3'b000, 0);
        sb.push_back(good(4'd15)); launch(4'd15); wait_done(0, 3'b000, 0);

        push(4'b0100, 0, 1, 2);
        launch(4'd5);
        wait_done(2, 3'b110, 0);
        push(4'b0101, 0, 1, 4);
        launch(4'd5);
        wait_done(4, 3'b010, 0);

        launch(4'd9);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check("midreset_no_done", n, 0);

        sb.push_back(good(4'd6));
        launch(4'd6);
        wait_done(0, 3'b000, 1);

        hold = 1'b1;
        sb.push_back(good(4'd3));
        launch(4'd3);
        wait_done(0, 3'b000, 0);
        sb.push_back(good(4'd12));
        @(posedge clk);
        #1;
        hold = 1'b0;
        start = 1'b0;
        target = 4'd12;
        check("b2b_busy", busy, 1);
        check("b2b_probe", probe, 4'b1000);
        wait_done(0, 3'b000, 0);

        for (int t = 0; t < 16; t++) begin
            sb.push_back(good(4'(t)));
            launch(4'(t));
            wait_done(0, 3'b000, 0);
        end
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
